// File: rtl/seg_adder_pkg.sv
// Shared types and helpers for the segmented adder: FSM encoding and counter sizing.
package seg_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cond_sum_seg.sv
// Combinational W-bit conditional-sum adder: lower half ripples with the real carry,
// upper half is precomputed for both carries and picked by the lower-half carry-out.
module cond_sum_seg #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] sum,
    output logic         co
);

    if (W == 1) begin : g_bit
        assign {co, sum} = {1'b0, a} + {1'b0, b} + {1'b0, ci};
    end else begin : g_split
        localparam int LO = W / 2;
        localparam int HI = W - LO;

        logic [LO:0] lo_r;
        logic [HI:0] hi_c0;
        logic [HI:0] hi_c1;

        assign lo_r  = {1'b0, a[LO-1:0]} + {1'b0, b[LO-1:0]} + {{LO{1'b0}}, ci};
        assign hi_c0 = {1'b0, a[W-1:LO]} + {1'b0, b[W-1:LO]};
        assign hi_c1 = {1'b0, a[W-1:LO]} + {1'b0, b[W-1:LO]} + {{HI{1'b0}}, 1'b1};

        assign {co, sum} = lo_r[LO] ? {hi_c1, lo_r[LO-1:0]} : {hi_c0, lo_r[LO-1:0]};
    end

endmodule

// File: rtl/seg_adder.sv
// Multi-cycle N-bit add/sub, one W-bit segment per clock; SEG_ADDER_OVF_EN enables ovf.
// Latency: out_valid visible NSEG+1 edges after accept (counting the accept edge).
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, no overlap.
module seg_adder
    import seg_adder_pkg::*;
#(
    parameter int N = 32,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         co,
    output logic         ovf
);

    if (W < 1 || (N % ((W < 1) ? 1 : W)) != 0) begin : g_bad_params
        $error("seg_adder: N must be a positive multiple of W (W >= 1)");
    end

    localparam int NSEG = N / ((W < 1) ? 1 : W);
    localparam int CW   = (NSEG > 1) ? clog2(NSEG) : 1;

    state_t         state_q, state_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic [N-1:0]   sum_q, sum_d;
    logic           carry_q, carry_d;
    logic           co_q, co_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    int unsigned    seg_lsb;
    logic [W-1:0]   seg_a;
    logic [W-1:0]   seg_b;
    logic [W-1:0]   seg_sum;
    logic           seg_co;
    logic           last_seg;

    assign seg_lsb  = 32'(cnt_q) * W;
    assign seg_a    = a_q[seg_lsb +: W];
    assign seg_b    = b_q[seg_lsb +: W];
    assign last_seg = (cnt_q == CW'(NSEG - 1));

    cond_sum_seg #(.W(W)) u_seg (
        .a   (seg_a),
        .b   (seg_b),
        .ci  (carry_q),
        .sum (seg_sum),
        .co  (seg_co)
    );

`ifdef SEG_ADDER_OVF_EN
    logic ovf_q, ovf_d;
    logic msb_cin;

    // Carry into the MSB recovered from the MSB's own sum bit.
    assign msb_cin = seg_a[W-1] ^ seg_b[W-1] ^ seg_sum[W-1];
    assign ovf     = ovf_q;
`else
    assign ovf     = 1'b0;
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign co        = co_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        co_d    = co_q;
        cnt_d   = cnt_q;
`ifdef SEG_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub | ci;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Consumed segments of A are reused as the partial-result store so the
                // visible sum only moves on the final edge.
                a_d[seg_lsb +: W] = seg_sum;
                carry_d           = seg_co;
                cnt_d             = cnt_q + CW'(1);
                if (last_seg) begin
                    sum_d   = a_d;
                    co_d    = seg_co;
`ifdef SEG_ADDER_OVF_EN
                    ovf_d   = msb_cin ^ seg_co;
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            co_q    <= co_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef SEG_ADDER_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end
`endif

endmodule
